// File: rtl/pwm_counter.sv
// pwm_counter: 16-bit PWM/timer time base.
// A prescaler divides chosen_clk by div_eff, the main counter steps 0..period_act-1
// on each prescaler tick and wraps, reloading the period shadow at every wrap so a
// mid-period write to period_reg never shortens or glitches the running period.
// Timer one-shot runs park in DONE after the first wrap and ask for ctrl[2] to clear.
module pwm_counter #(
    parameter int CW = 16
) (
    input  logic          chosen_clk,
    input  logic          rst,
    input  logic          counter_en,
    input  logic          mode,
    input  logic          cont,
    input  logic          irq_en,
    input  logic          cnt_rst,
    input  logic          irq_clr,
    input  logic [CW-1:0] divisor,
    input  logic [CW-1:0] period_reg,
    output logic [CW-1:0] counter,
    output logic          tick,
    output logic          period_done,
    output logic          irq_flag,
    output logic          en_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] ZERO = '0;
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic [CW-1:0] div_cnt;
    logic [CW-1:0] period_act;
    logic [CW-1:0] div_eff;
    logic          tick_nxt;
    logic          wrap_nxt;
    logic          en_clr_nxt;

    // A divisor of 0 behaves as divide-by-1.
    always_comb begin
        div_eff = (divisor == ZERO) ? ONE : divisor;
    end

    // Next state and the registered strobes that accompany the counter update.
    always_comb begin
        state_nxt  = state;
        tick_nxt   = 1'b0;
        wrap_nxt   = 1'b0;
        en_clr_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (counter_en) state_nxt = RUN;
            end
            RUN: begin
                if (!counter_en) begin
                    state_nxt = IDLE;
                end else begin
                    tick_nxt = (div_cnt == div_eff - ONE);
                    // A zero period never wraps; >= also catches a period shrunk below the count.
                    wrap_nxt = tick_nxt && (period_act != ZERO) && (counter >= period_act - ONE);
                    if (wrap_nxt && !mode && !cont) begin
                        state_nxt  = DONE;
                        en_clr_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!counter_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Counter clear overrides counting; it only changes state to release a finished one-shot.
        if (cnt_rst) begin
            state_nxt  = (state == DONE) ? IDLE : state;
            tick_nxt   = 1'b0;
            wrap_nxt   = 1'b0;
            en_clr_nxt = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge chosen_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Prescaler, main counter, period shadow and output strobes.
    always_ff @(posedge chosen_clk or posedge rst) begin
        if (rst) begin
            counter     <= ZERO;
            div_cnt     <= ZERO;
            period_act  <= ZERO;
            tick        <= 1'b0;
            period_done <= 1'b0;
            en_clr      <= 1'b0;
        end else begin
            tick        <= tick_nxt;
            period_done <= wrap_nxt;
            en_clr      <= en_clr_nxt;
            if (cnt_rst) begin
                counter    <= ZERO;
                div_cnt    <= ZERO;
                period_act <= period_reg;
            end else begin
                case (state)
                    IDLE: begin
                        div_cnt <= ZERO;
                        if (counter_en) period_act <= period_reg;
                    end
                    RUN: begin
                        if (!counter_en) begin
                            // Pause: counter holds so a later enable resumes where it stopped.
                            div_cnt <= ZERO;
                        end else begin
                            div_cnt <= tick_nxt ? ZERO : div_cnt + ONE;
                            if (tick_nxt) begin
                                if (wrap_nxt) begin
                                    counter    <= ZERO;
                                    period_act <= period_reg;
                                end else if (period_act == ZERO) begin
                                    counter <= ZERO;
                                end else begin
                                    counter <= counter + ONE;
                                end
                            end
                        end
                    end
                    DONE: begin
                        counter <= ZERO;
                        div_cnt <= ZERO;
                    end
                    default: begin
                        div_cnt <= ZERO;
                    end
                endcase
            end
        end
    end

    // Sticky interrupt: a wrap sets it (beating a simultaneous clear), irq_clr clears it.
    always_ff @(posedge chosen_clk or posedge rst) begin
        if (rst)                    irq_flag <= 1'b0;
        else if (wrap_nxt && irq_en) irq_flag <= 1'b1;
        else if (irq_clr)           irq_flag <= 1'b0;
    end

endmodule

// File: tb/tb_pwm_counter.sv
// tb_pwm_counter: directed stimulus for pwm_counter, checked every cycle against
// a behavioural model plus hand-computed literal expectations.
module tb_pwm_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        counter_en = 1'b0;
    logic        mode = 1'b0;
    logic        cont = 1'b0;
    logic        irq_en = 1'b0;
    logic        cnt_rst = 1'b0;
    logic        irq_clr = 1'b0;
    logic [15:0] divisor = 16'd1;
    logic [15:0] period_reg = 16'd0;
    logic [15:0] counter;
    logic        tick;
    logic        period_done;
    logic        irq_flag;
    logic        en_clr;

    int vectors = 0;
    int miscompares = 0;

    pwm_counter #(.CW(16)) dut (
        .chosen_clk (clk),
        .rst        (rst),
        .counter_en (counter_en),
        .mode       (mode),
        .cont       (cont),
        .irq_en     (irq_en),
        .cnt_rst    (cnt_rst),
        .irq_clr    (irq_clr),
        .divisor    (divisor),
        .period_reg (period_reg),
        .counter    (counter),
        .tick       (tick),
        .period_done(period_done),
        .irq_flag   (irq_flag),
        .en_clr     (en_clr)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase = cycles elapsed since the last tick, run = 0 idle / 1 running / 2 finished.
    int m_run = 0, m_ph = 0, m_cnt = 0, m_per = 0;
    bit m_tick = 0, m_done = 0, m_enclr = 0, m_flag = 0;

    always @(posedge clk or posedge rst) begin : model
        int run, ph, c, p, deff;
        bit tk, wr, ec, fl;
        if (rst) begin
            m_run <= 0; m_ph <= 0; m_cnt <= 0; m_per <= 0;
            m_tick <= 0; m_done <= 0; m_enclr <= 0; m_flag <= 0;
        end else begin
            run = m_run; ph = m_ph; c = m_cnt; p = m_per; fl = m_flag;
            tk = 0; wr = 0; ec = 0;
            deff = (divisor == 16'd0) ? 1 : int'(divisor);
            if (cnt_rst) begin
                c = 0; ph = 0; p = int'(period_reg);
                if (run == 2) run = 0;
            end else if (run == 0) begin
                ph = 0;
                if (counter_en) begin p = int'(period_reg); run = 1; end
            end else if (run == 1) begin
                if (!counter_en) begin
                    run = 0; ph = 0;
                end else begin
                    ph = ph + 1;
                    if (ph == deff) begin
                        ph = 0; tk = 1;
                        if (p > 0 && c + 1 >= p) begin
                            wr = 1; c = 0; p = int'(period_reg);
                            if (!mode && !cont) begin run = 2; ec = 1; end
                        end else if (p > 0) begin
                            c = c + 1;
                        end
                    end
                end
            end else begin
                c = 0; ph = 0;
                if (!counter_en) run = 0;
            end
            if (wr && irq_en) fl = 1;
            else if (irq_clr) fl = 0;
            m_run <= run; m_ph <= ph; m_cnt <= c; m_per <= p;
            m_tick <= tk; m_done <= wr; m_enclr <= ec; m_flag <= fl;
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        vectors++;
        if (int'(counter) != m_cnt || tick !== m_tick || period_done !== m_done ||
            irq_flag !== m_flag || en_clr !== m_enclr) begin
            miscompares++;
            $display("FAIL model t=%0t counter=%0d want %0d tick=%b want %b done=%b want %b irq=%b want %b en_clr=%b want %b",
                     $time, counter, m_cnt, tick, m_tick, period_done, m_done,
                     irq_flag, m_flag, en_clr, m_enclr);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(2);
        chk("rst_counter", int'(counter), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_done", int'(period_done), 0);
        chk("rst_irq", int'(irq_flag), 0);
        chk("rst_en_clr", int'(en_clr), 0);
        rst = 1'b0;

        // PWM, divide-by-1, period 4: 0,1,2,3,0,...
        divisor = 16'd1; period_reg = 16'd4; mode = 1'b1; counter_en = 1'b1;
        cyc(1);                                      // edge N: IDLE->RUN
        chk("t1_start", int'(counter), 0);
        cyc(3);                                      // N+3
        chk("t1_cnt3", int'(counter), 3);
        cyc(1);                                      // N+4: wrap
        chk("t1_wrap_cnt", int'(counter), 0);
        chk("t1_wrap_done", int'(period_done), 1);
        cyc(1);
        chk("t1_done_1cyc", int'(period_done), 0);
        chk("t1_cnt1", int'(counter), 1);
        cyc(6);
        chk("t1_no_irq", int'(irq_flag), 0);

        // Divide-by-3, period 2.
        counter_en = 1'b0; cnt_rst = 1'b1;
        cyc(1);
        chk("t2_cnt_rst", int'(counter), 0);
        cnt_rst = 1'b0;
        cyc(1);                                      // RUN->IDLE
        divisor = 16'd3; period_reg = 16'd2; counter_en = 1'b1;
        cyc(3);                                      // N+2
        chk("t2_no_tick_yet", int'(tick), 0);
        chk("t2_cnt_hold", int'(counter), 0);
        cyc(1);                                      // N+3
        chk("t2_tick", int'(tick), 1);
        chk("t2_cnt1", int'(counter), 1);
        cyc(3);                                      // N+6
        chk("t2_wrap_done", int'(period_done), 1);
        chk("t2_wrap_cnt", int'(counter), 0);
        cyc(6);

        // Timer one-shot, period 5, wrap coinciding with irq_clr.
        counter_en = 1'b0;
        cyc(1);
        cnt_rst = 1'b1;
        cyc(1);
        cnt_rst = 1'b0;
        mode = 1'b0; cont = 1'b0; irq_en = 1'b1; divisor = 16'd1; period_reg = 16'd5; counter_en = 1'b1;
        cyc(5);                                      // N+4
        chk("t3_cnt4", int'(counter), 4);
        irq_clr = 1'b1;
        cyc(1);                                      // N+5: wrap
        irq_clr = 1'b0;
        chk("t3_wrap_cnt", int'(counter), 0);
        chk("t3_en_clr", int'(en_clr), 1);
        chk("t3_irq_set_wins", int'(irq_flag), 1);
        cyc(1);
        chk("t3_en_clr_1cyc", int'(en_clr), 0);
        cyc(3);
        chk("t3_frozen", int'(counter), 0);
        chk("t3_no_rewrap", int'(period_done), 0);
        counter_en = 1'b0;
        cyc(1);
        irq_clr = 1'b1;
        cyc(1);
        irq_clr = 1'b0;
        chk("t3_irq_cleared", int'(irq_flag), 0);

        // Continuous timer, period 10 shrunk to 3 at count 7.
        cont = 1'b1; period_reg = 16'd10; counter_en = 1'b1;
        cyc(8);                                      // N+7
        chk("t4_cnt7", int'(counter), 7);
        period_reg = 16'd3;
        cyc(2);                                      // N+9
        chk("t4_cnt9", int'(counter), 9);
        cyc(1);                                      // N+10
        chk("t4_wrap_old", int'(period_done), 1);
        cyc(2);
        chk("t4_cnt2", int'(counter), 2);
        cyc(1);                                      // N+13
        chk("t4_wrap_new", int'(period_done), 1);
        chk("t4_wrap_cnt", int'(counter), 0);

        // Pause and resume, divisor 0 acting as 1.
        counter_en = 1'b0;
        cyc(1);
        cnt_rst = 1'b1;
        cyc(1);
        cnt_rst = 1'b0;
        mode = 1'b1; divisor = 16'd0; period_reg = 16'd10; counter_en = 1'b1;
        cyc(7);                                      // N+6
        chk("t5_cnt6", int'(counter), 6);
        counter_en = 1'b0;
        cyc(5);
        chk("t5_hold", int'(counter), 6);
        counter_en = 1'b1;
        cyc(1);
        chk("t5_reenter", int'(counter), 6);
        cyc(1);
        chk("t5_resume", int'(counter), 7);
        cnt_rst = 1'b1;
        cyc(1);
        cnt_rst = 1'b0;
        chk("t5_cnt_rst", int'(counter), 0);

        // Zero period: counter pinned at 0, no wraps.
        period_reg = 16'd0; cnt_rst = 1'b1;
        cyc(1);
        cnt_rst = 1'b0;
        cyc(6);
        chk("t7_zero_per_cnt", int'(counter), 0);
        chk("t7_zero_per_done", int'(period_done), 0);

        // Asynchronous reset mid-period.
        divisor = 16'd1; period_reg = 16'd4; irq_en = 1'b1; cnt_rst = 1'b1;
        cyc(1);
        cnt_rst = 1'b0;
        cyc(7);
        chk("t6_cnt3", int'(counter), 3);
        chk("t6_irq1", int'(irq_flag), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_cnt", int'(counter), 0);
        chk("t6_async_irq", int'(irq_flag), 0);
        chk("t6_async_tick", int'(tick), 0);
        chk("t6_async_done", int'(period_done), 0);
        chk("t6_async_en_clr", int'(en_clr), 0);
        cyc(2);
        rst = 1'b0;
        cyc(1);                                      // IDLE->RUN
        chk("t6_idle_after_rst", int'(counter), 0);
        cyc(1);
        chk("t6_run", int'(counter), 1);
        cyc(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
